// File: rtl/fifo_test_status_monitor.sv
// rtl/fifo_test_status_monitor.sv - N-channel FIFO self-test status/LED monitor
// Synchronises per-channel flags, latches errors, stretches full/empty and blink-codes the first failing channel.

module fifo_test_status_monitor #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGE  = 2,
  parameter int BLINK_DIV_W = 20,
  parameter int TICK_W      = 18,
  parameter int PULSE_TICKS = 2,
  parameter int GAP_TICKS   = 6,
  parameter int STRETCH_CYC = 1024,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              led_clk,
  input  logic              sys_rst,
  input  logic [NUM_CH-1:0] ch_error_i,
  input  logic [NUM_CH-1:0] ch_full_i,
  input  logic [NUM_CH-1:0] ch_empty_i,
  input  logic              clear_err_i,
  output logic              led_blink,
  output logic              led_error,
  output logic              led_full,
  output logic              led_empty,
  output logic [NUM_CH-1:0] err_sticky_o,
  output logic [CH_W-1:0]   first_err_ch_o,
  output logic              first_err_vld_o
);

  localparam int SW    = 3 * NUM_CH;
  localparam int STR_W = $clog2(STRETCH_CYC + 1);
  localparam int TMAX  = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
  localparam int TC_W  = $clog2(TMAX + 1);
  localparam int PC_W  = CH_W + 1;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  logic [SYNC_STAGE*SW-1:0] sync_pipe;
  logic [SW-1:0]            synced;
  logic [NUM_CH-1:0]        err_s, full_s, empty_s;
  logic [BLINK_DIV_W-1:0]   hb_cnt;
  logic                     blink_q;
  logic [TICK_W-1:0]        tick_cnt;
  logic                     tick;
  logic [CH_W-1:0]          low_idx;
  logic [NUM_CH-1:0]        sticky_base;
  logic                     fsm_clear;
  logic [STR_W-1:0]         full_cnt, empty_cnt;
  state_t                   state_q, state_d;
  logic [TC_W-1:0]          tcnt_q, tcnt_d;
  logic [PC_W-1:0]          pcnt_q, pcnt_d;
  logic                     led_error_d;

  // All three flag groups share one shift pipe; the last SW bits are the synced view.
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) sync_pipe <= '0;
    else         sync_pipe <= {sync_pipe[(SYNC_STAGE-1)*SW-1:0], ch_empty_i, ch_full_i, ch_error_i};
  end

  assign synced  = sync_pipe[SYNC_STAGE*SW-1 -: SW];
  assign err_s   = synced[NUM_CH-1:0];
  assign full_s  = synced[2*NUM_CH-1:NUM_CH];
  assign empty_s = synced[SW-1:2*NUM_CH];

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hb_cnt   <= '0;
      blink_q  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      hb_cnt   <= hb_cnt + BLINK_DIV_W'(1);
      tick_cnt <= tick_cnt + TICK_W'(1);
      if (&hb_cnt) blink_q <= ~blink_q;
    end
  end

  assign tick = &tick_cnt;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (err_s[i]) low_idx = CH_W'(i);
    end
  end

  // A clear empties the capture first, so a synced error in the same cycle re-captures.
  assign sticky_base = clear_err_i ? '0 : err_sticky_o;
  assign fsm_clear   = clear_err_i & ~(|err_s);

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err_sticky_o    <= '0;
      first_err_ch_o  <= '0;
      first_err_vld_o <= 1'b0;
    end else begin
      err_sticky_o <= sticky_base | err_s;
      if ((sticky_base == '0) && (|err_s)) begin
        first_err_ch_o  <= low_idx;
        first_err_vld_o <= 1'b1;
      end else if (clear_err_i) begin
        first_err_ch_o  <= '0;
        first_err_vld_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      full_cnt  <= '0;
      empty_cnt <= '0;
    end else begin
      if (|full_s)                full_cnt  <= STR_W'(STRETCH_CYC);
      else if (full_cnt != '0)    full_cnt  <= full_cnt - STR_W'(1);
      if (|empty_s)               empty_cnt <= STR_W'(STRETCH_CYC);
      else if (empty_cnt != '0)   empty_cnt <= empty_cnt - STR_W'(1);
    end
  end

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Phases end on the tick that would take tcnt to zero.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    pcnt_d      = pcnt_q;
    led_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (first_err_vld_o) begin
          state_d = ON;
          tcnt_d  = TC_W'(PULSE_TICKS);
          pcnt_d  = {1'b0, first_err_ch_o} + PC_W'(1);
        end
      end
      ON: begin
        led_error_d = 1'b1;
        if (tick) begin
          if (tcnt_q <= TC_W'(1)) begin
            state_d = OFF;
            tcnt_d  = TC_W'(PULSE_TICKS);
          end else begin
            tcnt_d = tcnt_q - TC_W'(1);
          end
        end
      end
      OFF: begin
        if (tick) begin
          if (tcnt_q <= TC_W'(1)) begin
            if (pcnt_q > PC_W'(1)) begin
              state_d = ON;
              pcnt_d  = pcnt_q - PC_W'(1);
              tcnt_d  = TC_W'(PULSE_TICKS);
            end else begin
              state_d = GAP;
              pcnt_d  = '0;
              tcnt_d  = TC_W'(GAP_TICKS);
            end
          end else begin
            tcnt_d = tcnt_q - TC_W'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (tcnt_q <= TC_W'(1)) begin
            state_d = IDLE;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q - TC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fsm_clear) begin
      state_d = IDLE;
      tcnt_d  = '0;
      pcnt_d  = '0;
    end
  end

  assign led_blink = blink_q;
  assign led_error = led_error_d;
  assign led_full  = (|full_s) | (full_cnt != '0);
  assign led_empty = (|empty_s) | (empty_cnt != '0);

endmodule

// File: tb/tb_fifo_test_status_monitor.sv
// tb/tb_fifo_test_status_monitor.sv - random + directed bench for fifo_test_status_monitor
// Reference model works in edge counts, input history and frame phases.

module tb_fifo_test_status_monitor;

  localparam int NUM_CH = 4;
  localparam int SS     = 2;
  localparam int BW     = 2;
  localparam int TW     = 2;
  localparam int PT     = 2;
  localparam int GT     = 4;
  localparam int SC     = 8;

  logic       led_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] ch_error_i = '0;
  logic [3:0] ch_full_i  = '0;
  logic [3:0] ch_empty_i = '0;
  logic       clear_err_i = 1'b0;
  logic       led_blink, led_error, led_full, led_empty;
  logic [3:0] err_sticky_o;
  logic [1:0] first_err_ch_o;
  logic       first_err_vld_o;

  fifo_test_status_monitor #(
    .NUM_CH(NUM_CH), .SYNC_STAGE(SS), .BLINK_DIV_W(BW), .TICK_W(TW),
    .PULSE_TICKS(PT), .GAP_TICKS(GT), .STRETCH_CYC(SC)
  ) dut (
    .led_clk(led_clk), .sys_rst(sys_rst),
    .ch_error_i(ch_error_i), .ch_full_i(ch_full_i), .ch_empty_i(ch_empty_i),
    .clear_err_i(clear_err_i),
    .led_blink(led_blink), .led_error(led_error), .led_full(led_full), .led_empty(led_empty),
    .err_sticky_o(err_sticky_o), .first_err_ch_o(first_err_ch_o), .first_err_vld_o(first_err_vld_o)
  );

  always #5 led_clk = ~led_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: n = edges since reset, h_* = input history, frames as phase index (even < 2(k+1) lit).
  int         n = 0;
  logic [3:0] h_err   [SS] = '{default: '0};
  logic [3:0] h_full  [SS] = '{default: '0};
  logic [3:0] h_empty [SS] = '{default: '0};
  logic [3:0] m_sticky = '0;
  bit         m_vld = 1'b0;
  int         m_ch = 0;
  int         last_full = -1000000;
  int         last_empty = -1000000;
  bit         m_active = 1'b0;
  int         m_phase = 0, m_left = 0, m_k = 0;

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < SS; i++) begin
      h_err[i] = '0; h_full[i] = '0; h_empty[i] = '0;
    end
    m_sticky = '0; m_vld = 1'b0; m_ch = 0;
    last_full = -1000000; last_empty = -1000000;
    m_active = 1'b0; m_phase = 0; m_left = 0; m_k = 0;
  endtask

  task automatic model_step();
    logic [3:0] se, base;
    bit tick, clr_eff;
    se      = h_err[SS-1];
    tick    = ((n % (1 << TW)) == ((1 << TW) - 1));
    clr_eff = clear_err_i && (se == 4'b0);
    if (clr_eff) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (m_vld) begin
        m_active = 1'b1; m_phase = 0; m_left = PT; m_k = m_ch;
      end
    end else if (tick) begin
      m_left--;
      if (m_left == 0) begin
        m_phase++;
        if (m_phase > 2 * (m_k + 1)) m_active = 1'b0;
        else m_left = (m_phase == 2 * (m_k + 1)) ? GT : PT;
      end
    end
    base = clear_err_i ? 4'b0 : m_sticky;
    if (base == 4'b0 && se != 4'b0) begin
      m_vld = 1'b1;
      for (int i = 3; i >= 0; i--) if (se[i]) m_ch = i;
    end else if (clear_err_i) begin
      m_vld = 1'b0; m_ch = 0;
    end
    m_sticky = base | se;
    if (|h_full[SS-1])  last_full  = n;
    if (|h_empty[SS-1]) last_empty = n;
    for (int i = SS - 1; i > 0; i--) begin
      h_err[i] = h_err[i-1]; h_full[i] = h_full[i-1]; h_empty[i] = h_empty[i-1];
    end
    h_err[0] = ch_error_i; h_full[0] = ch_full_i; h_empty[0] = ch_empty_i;
    n++;
  endtask

  always @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) model_reset();
    else         model_step();
  end

  always @(negedge led_clk) begin
    int exp_err, exp_full, exp_empty;
    exp_err   = (m_active && (m_phase % 2 == 0) && (m_phase < 2 * (m_k + 1))) ? 1 : 0;
    exp_full  = ((|h_full[SS-1])  || (n - last_full  <= SC)) ? 1 : 0;
    exp_empty = ((|h_empty[SS-1]) || (n - last_empty <= SC)) ? 1 : 0;
    chk("blink",  int'(led_blink), (n >> BW) & 1);
    chk("error",  int'(led_error), exp_err);
    chk("full",   int'(led_full),  exp_full);
    chk("empty",  int'(led_empty), exp_empty);
    chk("sticky", int'(err_sticky_o), int'(m_sticky));
    chk("ch",     int'(first_err_ch_o), m_ch);
    chk("vld",    int'(first_err_vld_o), int'(m_vld));
  end

  task automatic nx();
    @(negedge led_clk);
    #1;
  endtask

  task automatic after_edges(input int k);
    repeat (k) @(posedge led_clk);
    #1;
  endtask

  task automatic wait_error_on(input string name);
    int g;
    g = 0;
    while (!led_error && g < 200) begin
      nx();
      g++;
    end
    chk(name, (g < 200) ? 1 : 0, 1);
  endtask

  // Skip to a dark gap, then count pulses up to the next gap; the second pulse has full length.
  task automatic frame_check(input string name, input int exp_pulses);
    int low, pulses, hi, len2;
    bit in_frame, prev, cur, done;
    low = 0; pulses = 0; hi = 0; len2 = -1;
    in_frame = 1'b0; prev = 1'b0; done = 1'b0;
    for (int g = 0; g < 400 && !done; g++) begin
      @(negedge led_clk);
      cur = led_error;
      if (cur) begin
        if (!prev) begin pulses++; hi = 0; end
        hi++;
        low = 0;
      end else begin
        if (prev && pulses == 2) len2 = hi;
        low++;
      end
      if (!in_frame && low >= 20) begin
        in_frame = 1'b1;
        pulses   = 0;
      end else if (in_frame && low >= 20 && pulses > 0) begin
        done = 1'b1;
      end
      prev = cur;
    end
    chk({name, "_done"}, int'(done), 1);
    chk({name, "_pulses"}, pulses, exp_pulses);
    if (exp_pulses >= 2) chk({name, "_on_len"}, len2, 8);
  endtask

  task automatic clear_pulse();
    clear_err_i = 1'b1;
    nx();
    clear_err_i = 1'b0;
  endtask

  initial begin
    int cnt;
    bit done;
    repeat (3) nx();
    sys_rst = 1'b0;

    after_edges(3);
    chk("blink_at3", int'(led_blink), 0);
    after_edges(1);
    chk("blink_at4", int'(led_blink), 1);
    repeat (20) nx();

    ch_error_i = 4'b0100;
    after_edges(3);
    chk("t2_sticky", int'(err_sticky_o), 4);
    chk("t2_ch", int'(first_err_ch_o), 2);
    chk("t2_vld", int'(first_err_vld_o), 1);
    frame_check("t2_frame", 3);

    nx(); ch_error_i = '0;
    repeat (3) nx();
    clear_pulse();
    chk("clr_sticky", int'(err_sticky_o), 0);
    chk("clr_vld", int'(first_err_vld_o), 0);

    ch_error_i = 4'b1010;
    after_edges(3);
    chk("t3_ch", int'(first_err_ch_o), 1);
    chk("t3_sticky", int'(err_sticky_o), 10);
    frame_check("t3_frame", 2);
    nx(); ch_error_i = 4'b1011;
    after_edges(3);
    chk("t3_sticky2", int'(err_sticky_o), 11);
    chk("t3_ch_frozen", int'(first_err_ch_o), 1);

    nx(); ch_error_i = '0;
    repeat (3) nx();
    wait_error_on("t4_wait_on");
    clear_err_i = 1'b1;
    after_edges(1);
    chk("t4_led_off", int'(led_error), 0);
    chk("t4_sticky", int'(err_sticky_o), 0);
    chk("t4_vld", int'(first_err_vld_o), 0);
    nx(); clear_err_i = 1'b0;

    ch_error_i = 4'b0001;
    repeat (4) nx();
    clear_pulse();
    chk("t4_set_wins", int'(err_sticky_o), 1);
    chk("t4_set_vld", int'(first_err_vld_o), 1);
    nx(); ch_error_i = '0;
    repeat (3) nx();
    clear_pulse();

    ch_full_i = 4'b1000;
    after_edges(1);
    chk("t5_rise_early", int'(led_full), 0);
    after_edges(1);
    chk("t5_rise", int'(led_full), 1);
    nx();
    nx(); ch_full_i = '0;
    cnt = 0; done = 1'b0;
    for (int g = 0; g < 40 && !done; g++) begin
      @(negedge led_clk);
      if (led_full) cnt++;
      else done = 1'b1;
    end
    chk("t5_hold", cnt, 9);

    nx();
    ch_error_i = 4'b0010; ch_full_i = 4'b0001; ch_empty_i = 4'b0100;
    repeat (4) nx();
    ch_full_i = '0; ch_empty_i = '0;
    wait_error_on("t6_wait_on");
    #2;
    sys_rst = 1'b1; ch_error_i = '0;
    #1;
    chk("t6_rst_error", int'(led_error), 0);
    chk("t6_rst_full", int'(led_full), 0);
    chk("t6_rst_empty", int'(led_empty), 0);
    chk("t6_rst_blink", int'(led_blink), 0);
    chk("t6_rst_sticky", int'(err_sticky_o), 0);
    chk("t6_rst_vld", int'(first_err_vld_o), 0);
    chk("t6_rst_ch", int'(first_err_ch_o), 0);
    repeat (2) nx();
    sys_rst = 1'b0;
    cnt = 0;
    repeat (100) begin
      nx();
      if (led_error) cnt++;
    end
    chk("t6_no_residual", cnt, 0);

    for (int c = 0; c < 3000; c++) begin
      int r;
      nx();
      r = $urandom_range(0, 99);
      if (r < 3)      ch_error_i[$urandom_range(0, 3)] = 1'b1;
      else if (r < 6) ch_error_i = '0;
      clear_err_i = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0)
        ch_full_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 7) == 0)
        ch_empty_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
    end
    nx();
    clear_err_i = 1'b0;
    nx();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
